// File: rtl/tile_board_renderer.sv
// tile_board_renderer: pipelined board tile renderer with a frame-counted row-flash sequencer.
// Define TILE_GRID_LINES_EN to draw GRID_RGB lines on the top/left edge of empty cells.
module tile_board_renderer #(
    parameter int ORG_X = 220,
    parameter int ORG_Y = 40,
    parameter int COLS = 10,
    parameter int ROWS = 20,
    parameter int SPRITE_W = 10,
    parameter int SCALE = 1,
    parameter int KIND_W = 4,
    parameter int NUM_KINDS = 10,
    parameter int ADDR_W = 17,
    parameter logic [11:0] KEY_RGB = 12'hFFF,
    parameter logic [11:0] GRID_RGB = 12'h333,
    parameter int FLASH_PERIOD = 4,
    parameter int FLASH_TOGGLES = 6
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      p_tick,
    input  logic                      visible,
    input  logic [9:0]                pixel_x,
    input  logic [9:0]                pixel_y,
    output logic [$clog2(COLS)-1:0]   cell_x,
    output logic [$clog2(ROWS)-1:0]   cell_y,
    input  logic [KIND_W-1:0]         cell_kind,
    output logic [ADDR_W-1:0]         spr_addr,
    input  logic [11:0]               spr_data,
    input  logic [11:0]               bg_rgb,
    input  logic                      flash_start,
    input  logic [ROWS-1:0]           flash_rows,
    output logic                      flash_busy,
    output logic                      flash_done,
    output logic [11:0]               rgb_out,
    output logic                      in_board
);
    localparam int CELL_PX = SPRITE_W << SCALE;
    localparam int SUB_W = $clog2(CELL_PX);
    localparam int FC_W = $clog2(FLASH_PERIOD + 1);
    localparam int TG_W = $clog2(FLASH_TOGGLES + 1);
    localparam logic [9:0] X_LO = 10'(ORG_X);
    localparam logic [9:0] X_HI = 10'(ORG_X + COLS * CELL_PX);
    localparam logic [9:0] Y_LO = 10'(ORG_Y);
    localparam logic [9:0] Y_HI = 10'(ORG_Y + ROWS * CELL_PX);
    localparam logic [ADDR_W-1:0] SPR_SZ = ADDR_W'(SPRITE_W * SPRITE_W);
    localparam logic [ADDR_W-1:0] SPR_W = ADDR_W'(SPRITE_W);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(CELL_PX - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t state, state_n;
    logic [SUB_W-1:0] sub_x, sub_y;
    logic in_x, in_y, win0, vis0, win1, vis1, win2, vis2, empty1, empty2;
    logic v1, v2, v3, flash_off, frame_edge;
    logic [KIND_W-1:0] kind_eff;
    logic [ADDR_W-1:0] addr_n;
    logic [11:0] rgb_n;
    logic phase_on, phase_n, done_n;
    logic [FC_W-1:0] frame_cnt, fc_n;
    logic [TG_W-1:0] tog_cnt, tc_n;
    logic [ROWS-1:0] flash_rows_q, rows_n;

    assign in_x = pixel_x >= X_LO && pixel_x < X_HI;
    assign in_y = pixel_y >= Y_LO && pixel_y < Y_HI;
    assign frame_edge = p_tick && pixel_x == '0 && pixel_y == '0;
    assign flash_off = state == RUN && !phase_on;
    assign flash_busy = state == RUN || flash_done;

    // Incremental cell tracking: x re-anchors every line at ORG_X, y on each line start at ORG_Y.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sub_x <= '0;
            cell_x <= '0;
            sub_y <= '0;
            cell_y <= '0;
            win0 <= 1'b0;
            vis0 <= 1'b0;
        end else if (p_tick) begin
            win0 <= in_x && in_y;
            vis0 <= visible;
            if (pixel_x == X_LO) begin
                sub_x <= '0;
                cell_x <= '0;
            end else if (in_x) begin
                sub_x <= sub_x == SUB_LAST ? '0 : sub_x + 1'b1;
                cell_x <= sub_x == SUB_LAST ? cell_x + 1'b1 : cell_x;
            end
            if (pixel_x == '0) begin
                if (pixel_y == Y_LO) begin
                    sub_y <= '0;
                    cell_y <= '0;
                end else if (in_y) begin
                    sub_y <= sub_y == SUB_LAST ? '0 : sub_y + 1'b1;
                    cell_y <= sub_y == SUB_LAST ? cell_y + 1'b1 : cell_y;
                end
            end
        end
    end

    always_comb begin
        kind_eff = (int'(cell_kind) >= NUM_KINDS || (flash_off && flash_rows_q[cell_y])) ? '0 : cell_kind;
        addr_n = kind_eff == '0 ? '0 :
                 ADDR_W'(kind_eff - 1'b1) * SPR_SZ + ADDR_W'(sub_y >> SCALE) * SPR_W + ADDR_W'(sub_x >> SCALE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
            empty1 <= 1'b0;
            win1 <= 1'b0;
            vis1 <= 1'b0;
            spr_addr <= '0;
            empty2 <= 1'b0;
            win2 <= 1'b0;
            vis2 <= 1'b0;
            rgb_out <= '0;
            in_board <= 1'b0;
        end else begin
            v1 <= p_tick;
            v2 <= v1;
            v3 <= v2;
            if (v1) begin
                empty1 <= kind_eff == '0;
                win1 <= win0;
                vis1 <= vis0;
                spr_addr <= addr_n;
            end
            if (v2) begin
                empty2 <= empty1;
                win2 <= win1;
                vis2 <= vis1;
            end
            if (v3) begin
                rgb_out <= rgb_n;
                in_board <= win2;
            end
        end
    end

`ifdef TILE_GRID_LINES_EN
    logic grid1, grid2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grid1 <= 1'b0;
            grid2 <= 1'b0;
        end else begin
            if (v1) grid1 <= sub_x == '0 || sub_y == '0;
            if (v2) grid2 <= grid1;
        end
    end

    always_comb
        rgb_n = !vis2 ? '0 :
                (win2 && empty2 && grid2) ? GRID_RGB :
                (!win2 || empty2 || spr_data == KEY_RGB) ? bg_rgb : spr_data;
`else
    always_comb
        rgb_n = !vis2 ? '0 : (!win2 || empty2 || spr_data == KEY_RGB) ? bg_rgb : spr_data;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            phase_on <= 1'b1;
            frame_cnt <= '0;
            tog_cnt <= '0;
            flash_rows_q <= '0;
            flash_done <= 1'b0;
        end else begin
            state <= state_n;
            phase_on <= phase_n;
            frame_cnt <= fc_n;
            tog_cnt <= tc_n;
            flash_rows_q <= rows_n;
            flash_done <= done_n;
        end
    end

    // A start always wins, even over a coincident frame boundary or the final toggle.
    always_comb begin
        state_n = state;
        phase_n = phase_on;
        fc_n = frame_cnt;
        tc_n = tog_cnt;
        rows_n = flash_rows_q;
        done_n = 1'b0;
        if (flash_start) begin
            state_n = RUN;
            phase_n = 1'b0;
            fc_n = '0;
            tc_n = '0;
            rows_n = flash_rows;
        end else if (state == RUN && frame_edge) begin
            if (frame_cnt == FC_W'(FLASH_PERIOD - 1)) begin
                fc_n = '0;
                phase_n = !phase_on;
                tc_n = tog_cnt + 1'b1;
                if (tog_cnt == TG_W'(FLASH_TOGGLES - 1)) begin
                    state_n = IDLE;
                    phase_n = 1'b1;
                    done_n = 1'b1;
                end
            end else begin
                fc_n = frame_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_tile_board_renderer.sv
// tb_tile_board_renderer: randomized raster stimulus against a division-based pixel and flash reference model.
module tb_tile_board_renderer;
    localparam int ORG_X = 220, ORG_Y = 40, COLS = 10, ROWS = 20, CELL = 20;
    localparam int PERIOD = 4, TOGGLES = 6;

    logic clk = 1'b0, reset_n = 1'b0, p_tick = 1'b0, visible = 1'b0, flash_start = 1'b0;
    logic [9:0] pixel_x = '0, pixel_y = '0;
    logic [3:0] cell_x, cell_kind;
    logic [4:0] cell_y;
    logic [16:0] spr_addr;
    logic [11:0] spr_data = '0, bg_rgb = '0, rgb_out;
    logic [19:0] flash_rows = '0;
    logic flash_busy, flash_done, in_board;
    logic [3:0] board [ROWS][COLS];
    bit scan [480];
    int checks = 0, errors = 0;
    bit running = 0;
    int f = 0;
    logic [19:0] mask = '0;
    logic done_cap, done1, busy0, busy1;

    always #5 clk = ~clk;

    tile_board_renderer dut (
        .clk(clk), .reset_n(reset_n), .p_tick(p_tick), .visible(visible),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .cell_x(cell_x), .cell_y(cell_y),
        .cell_kind(cell_kind), .spr_addr(spr_addr), .spr_data(spr_data), .bg_rgb(bg_rgb),
        .flash_start(flash_start), .flash_rows(flash_rows), .flash_busy(flash_busy),
        .flash_done(flash_done), .rgb_out(rgb_out), .in_board(in_board)
    );

    function automatic logic [11:0] rom_val(input logic [16:0] a);
        int v;
        v = int'(a);
        return (v % 7 == 0) ? 12'hFFF : 12'(v * 37 + 5) & 12'hFFE;
    endfunction

    function automatic logic [11:0] bg_val(input int x, input int y);
        return 12'(x * 3 + y * 5 + 1);
    endfunction

    assign cell_kind = (int'(cell_x) < COLS && int'(cell_y) < ROWS) ? board[cell_y][cell_x] : 4'd0;
    always @(posedge clk) spr_data <= rom_val(spr_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int x, input int y, input bit vis, input bit start, input logic [19:0] rows);
        pixel_x = 10'(x);
        pixel_y = 10'(y);
        visible = vis;
        bg_rgb = bg_val(x, y);
        flash_start = start;
        flash_rows = rows;
        p_tick = 1'b1;
        @(negedge clk);
        done_cap = flash_done;
        busy0 = flash_busy;
        p_tick = 1'b0;
        flash_start = 1'b0;
        @(negedge clk);
        done1 = flash_done;
        busy1 = flash_busy;
        repeat (2) @(negedge clk);
    endtask

    task automatic pix(input int x, input int y, input bit vis);
        int cx, cy, sx, sy, k, a;
        bit inb;
        logic [11:0] rom, e;
        tick(x, y, vis, 1'b0, '0);
        inb = x >= ORG_X && x < ORG_X + COLS * CELL && y >= ORG_Y && y < ORG_Y + ROWS * CELL;
        e = vis ? bg_val(x, y) : 12'h000;
        if (inb) begin
            cx = (x - ORG_X) / CELL;
            sx = (x - ORG_X) % CELL;
            cy = (y - ORG_Y) / CELL;
            sy = (y - ORG_Y) % CELL;
            k = int'(board[cy][cx]);
            if (k >= 10 || (running && (f / PERIOD) % 2 == 0 && mask[cy])) k = 0;
            a = k == 0 ? 0 : (k - 1) * 100 + (sy / 2) * 10 + sx / 2;
            rom = rom_val(17'(a));
            if (vis && k != 0 && rom != 12'hFFF) e = rom;
`ifdef TILE_GRID_LINES_EN
            if (vis && k == 0 && (sx == 0 || sy == 0)) e = 12'h333;
`endif
            check($sformatf("addr@%0d,%0d", x, y), 32'(spr_addr), a);
            if (x == 290 && y == 150 && k == 2) check("addr_cell_3_5", 32'(spr_addr), 32'd155);
        end
        check($sformatf("rgb@%0d,%0d", x, y), 32'(rgb_out), 32'(e));
        check($sformatf("in_board@%0d,%0d", x, y), 32'(in_board), 32'(inb));
    endtask

    task automatic boundary(input bit start, input logic [19:0] rows);
        bit ed;
        ed = 0;
        tick(0, 0, 1'b1, start, rows);
        if (start) begin
            running = 1;
            f = 0;
            mask = rows;
        end else if (running) begin
            f++;
            if (f == PERIOD * TOGGLES) begin
                running = 0;
                ed = 1;
            end
        end
        check($sformatf("flash_done_f%0d", f), 32'(done_cap), 32'(ed));
        check("done_width", 32'(done1), 0);
        if (running) check("flash_busy", 32'(busy0), 1);
        else if (!ed) check("flash_idle", 32'(busy0), 0);
        if (ed) check("busy_after_done", 32'(busy1), 0);
        check("rgb@0,0", 32'(rgb_out), 32'(bg_val(0, 0)));
    endtask

    task automatic start_only(input logic [19:0] rows);
        flash_start = 1'b1;
        flash_rows = rows;
        @(negedge clk);
        flash_start = 1'b0;
        check("busy_on_start", 32'(flash_busy), 1);
        check("no_done_on_start", 32'(flash_done), 0);
        running = 1;
        f = 0;
        mask = rows;
    endtask

    task automatic frame(input int ymax);
        boundary(1'b0, '0);
        for (int y = 1; y <= ymax; y++) begin
            pix(0, y, 1'b1);
            if (scan[y])
                for (int x = ORG_X - 3; x < ORG_X + COLS * CELL + 3; x++) pix(x, y, $urandom_range(0, 40) != 0);
        end
    endtask

    task automatic clear_scan();
        foreach (scan[i]) scan[i] = 0;
    endtask

    task automatic random_board();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                board[r][c] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
    endtask

    initial begin
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) board[r][c] = 4'd0;
        clear_scan();
        repeat (3) @(negedge clk);
        check("rst_rgb", 32'(rgb_out), 0);
        check("rst_in_board", 32'(in_board), 0);
        check("rst_busy", 32'(flash_busy), 0);
        check("rst_done", 32'(flash_done), 0);
        check("rst_addr", 32'(spr_addr), 0);
        check("rst_cell_x", 32'(cell_x), 0);
        check("rst_cell_y", 32'(cell_y), 0);
        reset_n = 1'b1;
        @(negedge clk);
        // empty board: window edges and background pass-through
        scan[39] = 1; scan[40] = 1; scan[41] = 1; scan[60] = 1;
        scan[61] = 1; scan[200] = 1; scan[439] = 1; scan[440] = 1;
        frame(479);
        // random board, including the (3,5) kind 2 cell and the empty cell at (1,1)
        random_board();
        board[5][3] = 4'd2;
        board[1][1] = 4'd0;
        clear_scan();
        scan[60] = 1; scan[61] = 1; scan[150] = 1; scan[$urandom_range(41, 438)] = 1;
        frame(441);
        // row 19 flash, rendered once per phase
        random_board();
        for (int c = 0; c < COLS; c++) board[19][c] = 4'($urandom_range(1, 9));
        clear_scan();
        scan[425] = 1;
        start_only(20'h80000);
        for (int i = 1; i <= PERIOD * TOGGLES; i++) begin
            if (i % 4 == 1) frame(426);
            else boundary(1'b0, '0);
        end
        frame(426);
        // restart mid-sequence
        start_only(20'($urandom));
        repeat (10) boundary(1'b0, '0);
        start_only(20'h80000 | 20'($urandom));
        repeat (26) boundary(1'b0, '0);
        // start coincident with a frame boundary
        boundary(1'b1, 20'($urandom));
        repeat (25) boundary(1'b0, '0);
        // reset mid-sequence aborts without flash_done
        start_only(20'($urandom));
        repeat (5) boundary(1'b0, '0);
        reset_n = 1'b0;
        #1;
        check("midrst_busy", 32'(flash_busy), 0);
        check("midrst_done", 32'(flash_done), 0);
        check("midrst_rgb", 32'(rgb_out), 0);
        check("midrst_in_board", 32'(in_board), 0);
        running = 0;
        f = 0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        repeat (30) boundary(1'b0, '0);
        random_board();
        clear_scan();
        scan[$urandom_range(40, 439)] = 1;
        frame(441);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tile_board_renderer.md
# tile_board_renderer

Parametrised pipelined renderer for the playfield of the VGA game display. Converts the raster position from the VGA sync generator into board cell coordinates using incremental counters (no dividers), fetches the cell kind from board storage, addresses the shared sprite ROM, and composites sprite pixels over the background with a colour key. Adds a frame-counted row-flash sequencer for line-clear animation. Sits between `vga_sync_reg`, the board state and the sprite/background `sram` instances, ahead of the final RGB register.

## Interface
- `ORG_X`, 220: board left edge in screen pixels
- `ORG_Y`, 40: board top edge in screen pixels
- `COLS`, 10: board columns
- `ROWS`, 20: board rows
- `SPRITE_W`, 10: sprite edge in ROM texels; sprites are square
- `SCALE`, 1: log2 screen pixels per texel; cell edge `CELL_PX = SPRITE_W << SCALE`
- `KIND_W`, 4: cell kind width
- `NUM_KINDS`, 10: legal kinds are 1..NUM_KINDS-1; 0 means empty
- `ADDR_W`, 17: sprite ROM address width
- `KEY_RGB`, 12'hFFF: transparent colour
- `GRID_RGB`, 12'h333: grid line colour
- `FLASH_PERIOD`, 4: frames per flash phase
- `FLASH_TOGGLES`, 6: phases per flash sequence

Ports:
- `clk` in 1: system clock
- `reset_n` in 1: asynchronous active-low reset
- `p_tick` in 1: pixel strobe from sync generator
- `visible` in 1: active video
- `pixel_x`, `pixel_y` in 10: raster position, valid on `p_tick`
- `cell_x` out $clog2(COLS): board column request
- `cell_y` out $clog2(ROWS): board row request
- `cell_kind` in KIND_W: combinational board read of `cell_x/cell_y`
- `spr_addr` out ADDR_W: sprite ROM address
- `spr_data` in 12: ROM data, 1-clock latency
- `bg_rgb` in 12: background pixel, aligned to `spr_data`
- `flash_start` in 1: one-clock pulse starting a flash sequence
- `flash_rows` in ROWS: rows to flash, sampled with `flash_start`
- `flash_busy` out 1: sequence running
- `flash_done` out 1: one-clock pulse at sequence end
- `rgb_out` out 12: composited pixel
- `in_board` out 1: `rgb_out` belongs to the board window

## Operation
- S0 (on `p_tick` only): `in_board` window is `ORG_X <= pixel_x < ORG_X+COLS*CELL_PX` and same for y. Column counters: `sub_x` reset to 0 and `cell_x` to 0 when `pixel_x == ORG_X`; otherwise `sub_x` increments, wraps at `CELL_PX-1` and increments `cell_x`. Row counters update on `p_tick` with `pixel_x == 0`: reset at `pixel_y == ORG_Y`, advance `sub_y`/`cell_y` per line likewise. Outside the window counters hold.
- S1: latch `cell_kind`; substitute 0 if kind ≥ NUM_KINDS or if flash phase is "off" and `flash_rows_q[cell_y]` is set. `spr_addr = (kind-1)*SPRITE_W*SPRITE_W + (sub_y>>SCALE)*SPRITE_W + (sub_x>>SCALE)`, computed in ADDR_W bits, with kind 0 driving address 0.
- S2: ROM read in flight; kind/sub/window flags delayed alongside.
- S3: `rgb_out` = 0 if not visible; else `bg_rgb` if outside board, kind 0, or `spr_data == KEY_RGB`; else `spr_data`.
- Flash FSM: IDLE -> RUN on `flash_start` (latch mask, phase=off, frame count 0). Frame boundary = `p_tick` with `pixel_x==0 && pixel_y==0`. In RUN, every FLASH_PERIOD boundaries toggle the phase; after FLASH_TOGGLES toggles go to IDLE and pulse `flash_done`. `flash_start` in RUN restarts with the new mask, without a `flash_done` pulse. In IDLE, phase is "on" and no substitution occurs.

## Timing
- Reset: `cell_x`, `cell_y`, sub counters, `spr_addr`, `rgb_out` = 0; `in_board`, `flash_busy`, `flash_done` = 0; FSM IDLE. Reset mid-sequence aborts it with no `flash_done`.
- Latency: `rgb_out`/`in_board` valid 3 clocks after the `p_tick` clock and held until the next update. `p_tick` spacing must be ≥4 clocks.
- `cell_x/cell_y` change only in the clock after `p_tick`; board storage has one full clock to respond.
- `flash_busy` is 1 from the clock after `flash_start` until the clock carrying `flash_done`.
- `flash_start` coincident with a frame boundary: the start wins and the frame count is 0.

## Configuration
- `TILE_GRID_LINES_EN` defined: in empty cells, pixels with `sub_x == 0` or `sub_y == 0` output `GRID_RGB`; this applies to flashed-off rows too.
- Undefined: empty cells show `bg_rgb` everywhere; no grid logic is synthesised.

## Test plan
- Reset, full frame with all cells kind 0 -> `in_board` exactly on x 220..419 and y 40..439; `rgb_out == bg_rgb` throughout.
- Cell (3,5) kind 2, SCALE=1 -> at screen (290,150) `spr_addr == 100+5*10+5 = 155`, `rgb_out == spr_data` 3 clocks after the `p_tick`.
- ROM returns 12'hFFF inside a kind 4 cell -> `rgb_out == bg_rgb`. Kind 12 -> treated as empty, `spr_addr == 0`.
- `flash_start` with `flash_rows = 1<<19` -> row 19 alternates empty/normal every 4 frames; `flash_done` appears after 24 frame boundaries; `flash_busy` is 0 on the next clock.
- Second `flash_start` at frame 10 of a sequence -> no `flash_done` at frame 24; `flash_done` appears 24 frames after the restart.
- With `TILE_GRID_LINES_EN`, empty cell at screen (240,60) -> `GRID_RGB`; screen (241,61) -> `bg_rgb`.
